// File: rtl/sr_reg_dump_pkg.sv
// Shared types and constants for the register dump block.
package sr_reg_dump_pkg;

  localparam int unsigned AddrWidth = 5;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned NumRegs   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StSend
  } dump_state_e;

  // Narrow an integer register index to a debug-port address.
  function automatic logic [AddrWidth-1:0] to_addr(int unsigned v);
    return v[AddrWidth-1:0];
  endfunction

endpackage

// File: rtl/sr_reg_dump_if.sv
// Debug read port toward the core plus the {addr, data} beat stream toward the host link.
interface sr_reg_dump_if;
  import sr_reg_dump_pkg::*;

  logic [AddrWidth-1:0] regAddr;
  logic [DataWidth-1:0] regData;
  logic                 outValid;
  logic                 outReady;
  logic [AddrWidth-1:0] outAddr;
  logic [DataWidth-1:0] outData;
  logic                 outLast;

  // Dump engine side.
  modport master (
    output regAddr,
    input  regData,
    output outValid,
    input  outReady,
    output outAddr,
    output outData,
    output outLast
  );

  // Core debug port and stream sink side.
  modport slave (
    input  regAddr,
    output regData,
    input  outValid,
    output outReady,
    input  outAddr,
    input  outData,
    input  outLast
  );

endinterface

// File: rtl/sr_reg_dump.sv
// Walks debug addresses FIRST_REG..LAST_REG, samples each value from the core's debug port and
// emits {address, data} beats on a valid/ready stream. busy doubles as a CPU halt request.
module sr_reg_dump
  import sr_reg_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  sr_reg_dump_if.master bus
);

  if (FIRST_REG > LAST_REG || LAST_REG > NumRegs - 1) begin : g_bad_params
    $error("sr_reg_dump: need FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [AddrWidth-1:0] FirstAddr = to_addr(FIRST_REG);
  localparam logic [AddrWidth-1:0] LastAddr  = to_addr(LAST_REG);

  dump_state_e          state_q;
  logic [AddrWidth-1:0] idx_q;
  logic                 out_valid_q;
  logic [AddrWidth-1:0] out_addr_q;
  logic [DataWidth-1:0] out_data_q;
  logic                 out_last_q;
  logic                 done_q;

  // Dump sequencer with all outputs registered; abort outranks a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q   <= FirstAddr;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StIdle;
          end else begin
            out_data_q  <= bus.regData;
            out_addr_q  <= idx_q;
            out_last_q  <= (idx_q == LastAddr);
            out_valid_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (abort) begin
            // Beat is withdrawn without a handshake; the sink tolerates this.
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StIdle;
          end else if (bus.outReady) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              // idx stays <= LAST_REG, so no address wrap.
              idx_q   <= idx_q + 1'b1;
              state_q <= StCapture;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Core sees the registered index only, so regData settles within the cycle.
  assign bus.regAddr  = idx_q;
  assign bus.outValid = out_valid_q;
  assign bus.outAddr  = out_addr_q;
  assign bus.outData  = out_data_q;
  assign bus.outLast  = out_last_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_sr_reg_dump.sv
// Bench for sr_reg_dump: a default-range instance (0..31) and a single-register instance (5..5)
// checked every cycle against a range-walking model plus directed literal expectations.
module tb_sr_reg_dump;

  logic       clk;
  logic       rst;
  logic [1:0] start;
  logic [1:0] abort;
  logic [1:0] rdy;

  logic busy0, busy1, done0, done1;
  logic [1:0] vld, lst, busy, done;
  logic [4:0] oaddr [2];
  logic [4:0] raddr [2];
  logic [31:0] odata [2];

  int checks;
  int errors;
  bit armed;

  sr_reg_dump_if bus0 ();
  sr_reg_dump_if bus1 ();

  // Core debug port: PC = 0x10, xN = N*0x11; the second core holds 0xDEADBEEF in x5.
  function automatic logic [31:0] core_val(int i, logic [4:0] a);
    if (a == 5'd0) return 32'h10;
    if (i == 1 && a == 5'd5) return 32'hDEADBEEF;
    return 32'(a) * 32'h11;
  endfunction

  function automatic logic [4:0] first_of(int i);
    return (i == 0) ? 5'd0 : 5'd5;
  endfunction

  function automatic logic [4:0] last_of(int i);
    return (i == 0) ? 5'd31 : 5'd5;
  endfunction

  assign bus0.regData  = core_val(0, bus0.regAddr);
  assign bus1.regData  = core_val(1, bus1.regAddr);
  assign bus0.outReady = rdy[0];
  assign bus1.outReady = rdy[1];

  sr_reg_dump #(.FIRST_REG(0), .LAST_REG(31)) u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start[0]),
    .abort (abort[0]),
    .busy  (busy0),
    .done  (done0),
    .bus   (bus0)
  );

  sr_reg_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start[1]),
    .abort (abort[1]),
    .busy  (busy1),
    .done  (done1),
    .bus   (bus1)
  );

  assign vld      = {bus1.outValid, bus0.outValid};
  assign lst      = {bus1.outLast, bus0.outLast};
  assign busy     = {busy1, busy0};
  assign done     = {done1, done0};
  assign oaddr[0] = bus0.outAddr;
  assign oaddr[1] = bus1.outAddr;
  assign odata[0] = bus0.outData;
  assign odata[1] = bus1.outData;
  assign raddr[0] = bus0.regAddr;
  assign raddr[1] = bus1.regAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a dump is "the remaining addresses nxt..last"; one address retires per handshake.
  logic [1:0]  busy_e, done_e, hold;
  logic [4:0]  nxt [2];
  logic [4:0]  held_addr [2];
  logic [31:0] held_data [2];
  int          beats [2];

  initial begin
    busy_e = '0;
    done_e = '0;
    hold   = '0;
    beats[0] = 0;
    beats[1] = 0;
    nxt[0] = '0;
    nxt[1] = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      hold[i]      <= vld[i] && !rdy[i] && !abort[i] && !rst;
      held_addr[i] <= oaddr[i];
      held_data[i] <= odata[i];
      if (rst) begin
        busy_e[i] <= 1'b0;
        done_e[i] <= 1'b0;
        nxt[i]    <= '0;
      end else begin
        done_e[i] <= 1'b0;
        if (!busy_e[i]) begin
          if (start[i]) begin
            busy_e[i] <= 1'b1;
            nxt[i]    <= first_of(i);
          end
        end else if (abort[i]) begin
          busy_e[i] <= 1'b0;
        end else if (vld[i] && rdy[i]) begin
          beats[i] <= beats[i] + 1;
          if (nxt[i] == last_of(i)) begin
            busy_e[i] <= 1'b0;
            done_e[i] <= 1'b1;
          end else begin
            nxt[i] <= nxt[i] + 5'd1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(busy_e[i]));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(done_e[i]));
        chk($sformatf("regAddr%0d", i), 32'(raddr[i]), 32'(nxt[i]));
        if (!busy_e[i]) chk($sformatf("idle_valid%0d", i), 32'(vld[i]), 32'd0);
        if (vld[i]) begin
          chk($sformatf("beat_addr%0d", i), 32'(oaddr[i]), 32'(nxt[i]));
          chk($sformatf("beat_data%0d", i), odata[i], core_val(i, nxt[i]));
          chk($sformatf("beat_last%0d", i), 32'(lst[i]), 32'(nxt[i] == last_of(i)));
        end
        if (hold[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(vld[i]), 32'd1);
          chk($sformatf("hold_addr%0d", i), 32'(oaddr[i]), 32'(held_addr[i]));
          chk($sformatf("hold_data%0d", i), odata[i], held_data[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int i, int max, output int k);
    k = 0;
    while (!done[i] && k < max) begin
      tick();
      k++;
    end
    chk($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
  endtask

  initial begin
    int k;
    int b0;
    rst   = 1'b1;
    start = '0;
    abort = '0;
    rdy   = 2'b11;
    armed = 1'b0;
    tick();
    armed = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(vld[i]), 32'd0);
      chk("rst_addr", 32'(oaddr[i]), 32'd0);
      chk("rst_data", odata[i], 32'd0);
      chk("rst_last", 32'(lst[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_regaddr", 32'(raddr[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Full default dump with a start pulse mid-dump that must be ignored.
    b0 = beats[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    k = 0;
    while (!done[0] && k < 200) begin
      tick();
      k++;
      if (k == 10) start[0] = 1'b1;
      if (k == 11) start[0] = 1'b0;
      if (k == 1) begin
        chk("first_valid", 32'(vld[0]), 32'd1);
        chk("first_addr", 32'(oaddr[0]), 32'd0);
        chk("first_pc", odata[0], 32'h0000_0010);
      end
      if (k == 3) chk("x1_data", odata[0], 32'h0000_0011);
      if (k == 63) begin
        chk("x31_addr", 32'(oaddr[0]), 32'd31);
        chk("x31_data", odata[0], 32'h0000_020F);
        chk("x31_last", 32'(lst[0]), 32'd1);
      end
    end
    chk("done_latency", 32'(k), 32'd64);
    chk("beats_full", 32'(beats[0] - b0), 32'd32);
    tick();
    chk("done_one_cycle", 32'(done[0]), 32'd0);

    // Backpressure: pseudo-random ready, model checks hold/order/no loss.
    b0 = beats[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    k = 0;
    while (!done[0] && k < 2000) begin
      rdy[0] = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk("bp_done", 32'(done[0]), 32'd1);
    chk("beats_bp", 32'(beats[0] - b0), 32'd32);
    rdy[0] = 1'b1;
    tick();

    // Single-register range.
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    tick();
    chk("one_valid", 32'(vld[1]), 32'd1);
    chk("one_addr", 32'(oaddr[1]), 32'd5);
    chk("one_data", odata[1], 32'hDEAD_BEEF);
    chk("one_last", 32'(lst[1]), 32'd1);
    tick();
    chk("one_done", 32'(done[1]), 32'd1);
    chk("one_busy", 32'(busy[1]), 32'd0);
    tick();

    // Abort on the third beat while the sink stalls.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    k = 0;
    while (!(vld[0] && oaddr[0] == 5'd2) && k < 20) begin
      tick();
      k++;
    end
    chk("third_beat_seen", 32'(oaddr[0]), 32'd2);
    rdy[0] = 1'b0;
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_valid", 32'(vld[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_last", 32'(lst[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    tick();
    chk("abort_no_done", 32'(done[0]), 32'd0);
    rdy[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("restart_addr", 32'(oaddr[0]), 32'd0);
    wait_done(0, 200, k);
    tick();

    // start and abort together while idle: start wins.
    start[1] = 1'b1;
    abort[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("start_abort_busy", 32'(busy[1]), 32'd1);
    wait_done(1, 20, k);
    tick();

    // Reset in the middle of a stalled beat.
    rdy[0] = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 32'(vld[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(vld[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_last", 32'(lst[0]), 32'd0);
    chk("mid_rst_data", odata[0], 32'd0);
    chk("mid_rst_regaddr", 32'(raddr[0]), 32'd0);
    rdy[0] = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
